button_event_debouncer: RTL and testbench

- Sits upstream of the Nios system's button PIO inputs and conditions raw active-low board keys.
- Each key passes through a two-flop synchronizer and a per-channel debounce FSM.
- Outputs are clean active-high levels that drive button_1_export/button_2_export, plus a small event FIFO with valid/ready handshake.
- Software or a future Avalon wrapper pops the FIFO to read press/release events without polling.

---
 rtl/button_event_debouncer.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_button_event_debouncer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_debouncer.sv
// button_event_debouncer: conditions raw active-low board keys into clean
// active-high levels and queues press/release events in a small FIFO.
// Each key goes through a two-flop synchronizer and a per-channel debounce FSM.
// Optional feature macro: LONG_PRESS_EN adds a per-channel hold counter that
// emits one long-press event (type 2'b10) per press.
module button_event_debouncer #(
  parameter int unsigned NUM_BUTTONS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [NUM_BUTTONS-1:0] key_n,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [7:0]             evt_data,
  output logic                   evt_overflow,
  input  logic                   overflow_clr
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  // A single debounce cycle could never match the terminal count, so reject it.
  if (NUM_BUTTONS < 1 || NUM_BUTTONS > 64 || DEBOUNCE_CYCLES < 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      LONG_PRESS_CYCLES < 1) begin : g_param_check
    $error("button_event_debouncer: illegal parameter set");
  end

  logic [NUM_BUTTONS-1:0] sync1_q;
  logic [NUM_BUTTONS-1:0] sync2_q;

  state_e           state_q [NUM_BUTTONS];
  state_e           state_d [NUM_BUTTONS];
  logic [CNT_W-1:0] cnt_q   [NUM_BUTTONS];
  logic [CNT_W-1:0] cnt_d   [NUM_BUTTONS];

  logic [NUM_BUTTONS-1:0] fsm_emit_c;
  logic [1:0]             fsm_type_c  [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] emit_c;
  logic [1:0]             emit_type_c [NUM_BUTTONS];

  logic [NUM_BUTTONS-1:0] pend_q;
  logic [1:0]             pend_type_q [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] grant_c;
  logic                   arb_found_c;
  logic                   push_c;
  logic                   pop_c;
  logic                   push_ok_c;
  logic [7:0]             push_data_c;
  logic                   ovf_set_c;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_d;
  logic [PW-1:0] rd_d;
  logic          full_c;
  logic          empty_c;
  logic [7:0]    head_d;

  // Two-flop synchronizer; idles high (released) out of reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM state and counter registers.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Debounce next-state: a level change is accepted after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      fsm_emit_c[i] = 1'b0;
      fsm_type_c[i] = EVT_PRESS;
      case (state_q[i])
        RELEASED: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        PRESS_CHK: begin
          if (sync2_q[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d[i]    = PRESSED;
            cnt_d[i]      = '0;
            fsm_emit_c[i] = 1'b1;
            fsm_type_c[i] = EVT_PRESS;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (sync2_q[i]) begin
            state_d[i] = RELEASE_CHK;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        RELEASE_CHK: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d[i]    = RELEASED;
            cnt_d[i]      = '0;
            fsm_emit_c[i] = 1'b1;
            fsm_type_c[i] = EVT_RELEASE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned HOLD_W   = $clog2(LONG_PRESS_CYCLES + 2);
  localparam logic [1:0]  EVT_LONG = 2'b10;

  logic [HOLD_W-1:0] hold_q [NUM_BUTTONS];
  logic [HOLD_W-1:0] hold_d [NUM_BUTTONS];

  // Hold counters survive release bounces and clear only back in RELEASED.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_BUTTONS; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) hold_q[i] <= hold_d[i];
    end
  end

  // Hold count saturates one past the threshold so the long press fires once.
  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      hold_d[i]      = hold_q[i];
      emit_c[i]      = fsm_emit_c[i];
      emit_type_c[i] = fsm_type_c[i];
      if (state_d[i] == RELEASED) begin
        hold_d[i] = '0;
      end else if (state_q[i] == PRESS_CHK && state_d[i] == PRESSED) begin
        hold_d[i] = HOLD_W'(1);
      end else if ((state_q[i] == PRESSED || state_q[i] == RELEASE_CHK) &&
                   hold_q[i] < HOLD_W'(LONG_PRESS_CYCLES + 1)) begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
      end
      // A release landing on the same cycle wins; the press is over anyway.
      if (!fsm_emit_c[i] && (state_q[i] == PRESSED || state_q[i] == RELEASE_CHK) &&
          hold_q[i] == HOLD_W'(LONG_PRESS_CYCLES)) begin
        emit_c[i]      = 1'b1;
        emit_type_c[i] = EVT_LONG;
      end
    end
  end
`else
  // Without long-press support only debounce events are produced.
  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      emit_c[i]      = fsm_emit_c[i];
      emit_type_c[i] = fsm_type_c[i];
    end
  end
`endif

  // Debounced level follows the registered FSM state.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      btn_level <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        btn_level[i] <= (state_q[i] == PRESSED) || (state_q[i] == RELEASE_CHK);
      end
    end
  end

  // One-deep pending slot per channel; an event arriving on a busy slot is lost.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pend_q       <= '0;
      evt_overflow <= 1'b0;
      for (int i = 0; i < NUM_BUTTONS; i++) pend_type_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (grant_c[i]) pend_q[i] <= 1'b0;
        if (emit_c[i] && !pend_q[i]) begin
          pend_q[i]      <= 1'b1;
          pend_type_q[i] <= emit_type_c[i];
        end
      end
      evt_overflow <= ovf_set_c | (evt_overflow & ~overflow_clr);
    end
  end

  assign ovf_set_c = |(emit_c & pend_q);

  assign full_c    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_c   = (wr_q == rd_q);
  assign pop_c     = !empty_c && evt_ready;
  assign push_ok_c = !full_c || pop_c;

  // Fixed-priority arbiter: lowest pending channel gets the single push slot.
  always_comb begin
    grant_c     = '0;
    arb_found_c = 1'b0;
    push_data_c = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (pend_q[i] && !arb_found_c) begin
        arb_found_c = 1'b1;
        grant_c[i]  = push_ok_c;
        push_data_c = {pend_type_q[i], 6'(i)};
      end
    end
    push_c = arb_found_c && push_ok_c;
  end

  // Next pointers and next head; bypass when the pushed entry becomes the head.
  always_comb begin
    wr_d = push_c ? wr_q + PW'(1) : wr_q;
    rd_d = pop_c  ? rd_q + PW'(1) : rd_q;
    if (wr_d == rd_d) begin
      head_d = '0;
    end else if (push_c && rd_d[AW-1:0] == wr_q[AW-1:0]) begin
      head_d = push_data_c;
    end else begin
      head_d = mem[rd_d[AW-1:0]];
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_clk) begin
    if (push_c) mem[wr_q[AW-1:0]] <= push_data_c;
  end

  // FIFO pointers and registered head.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      evt_valid <= 1'b0;
      evt_data  <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      evt_valid <= (wr_d != rd_d);
      evt_data  <= head_d;
    end
  end

endmodule

// File: tb/tb_button_event_debouncer.sv
// Testbench for button_event_debouncer: table-driven press/release vectors,
// hand-written corner sequences, and an event scoreboard checked on each pop.
module tb_button_event_debouncer;

  localparam int unsigned NB    = 2;
  localparam int unsigned DEB   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LONG  = 40;

  logic          clk_clk       = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic [NB-1:0] key_n         = '1;
  logic [NB-1:0] btn_level;
  logic          evt_valid;
  logic          evt_ready     = 1'b1;
  logic [7:0]    evt_data;
  logic          evt_overflow;
  logic          overflow_clr  = 1'b0;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [NB-1:0] key_n;
    int            hold;
    logic [NB-1:0] lvl;
    int            n_evt;
    logic [7:0]    evt0;
    logic [7:0]    evt1;
  } vec_t;

  vec_t vecs [3];

  button_event_debouncer #(
    .NUM_BUTTONS      (NB),
    .DEBOUNCE_CYCLES  (DEB),
    .FIFO_DEPTH       (DEPTH),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .key_n        (key_n),
    .btn_level    (btn_level),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .evt_overflow (evt_overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted event must match the oldest expected one.
  task automatic monitor_sample();
    logic [7:0] exp;
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_evt: got 0x%0h expected none", evt_data);
      end else begin
        exp = exp_q.pop_front();
        check("evt_order", 32'(evt_data), 32'(exp));
      end
    end
  endtask

  // Advance n cycles: sample at the falling edge, return 1 ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_clk);
      monitor_sample();
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    logic bounce_hi;

    vecs[0] = '{key_n: 2'b10, hold: 20, lvl: 2'b01, n_evt: 1, evt0: 8'h00, evt1: 8'h00};
    vecs[1] = '{key_n: 2'b01, hold: 20, lvl: 2'b10, n_evt: 1, evt0: 8'h01, evt1: 8'h00};
    vecs[2] = '{key_n: 2'b00, hold: 20, lvl: 2'b11, n_evt: 2, evt0: 8'h00, evt1: 8'h01};

    // Reset state
    tick(2);
    reset_reset_n = 1'b1;
    check("rst_level",    32'(btn_level),    32'd0);
    check("rst_valid",    32'(evt_valid),    32'd0);
    check("rst_data",     32'(evt_data),     32'd0);
    check("rst_overflow", 32'(evt_overflow), 32'd0);
    tick(2);

    // Bounce: 3-cycle pulses never satisfy the debounce window
    bounce_hi = 1'b0;
    for (int c = 0; c < 30; c++) begin
      key_n[0] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
      if (btn_level !== 2'b00) bounce_hi = 1'b1;
    end
    key_n[0] = 1'b1;
    tick(12);
    check("bounce_level", 32'(bounce_hi), 32'd0);
    check("bounce_no_evt", 32'(evt_valid), 32'd0);

    // Table: clean presses with exact rise/fall latency and event order
    for (int v = 0; v < 3; v++) begin
      key_n = vecs[v].key_n;
      exp_q.push_back(vecs[v].evt0);
      if (vecs[v].n_evt == 2) exp_q.push_back(vecs[v].evt1);
      tick(DEB + 2);
      check("lvl_pre_rise", 32'(btn_level), 32'd0);
      tick(1);
      check("lvl_rise", 32'(btn_level), 32'(vecs[v].lvl));
      check("evt_head0", 32'({evt_valid, evt_data}), 32'({1'b1, vecs[v].evt0}));
      if (vecs[v].n_evt == 2) begin
        tick(1);
        check("evt_head1", 32'({evt_valid, evt_data}), 32'({1'b1, vecs[v].evt1}));
        tick(vecs[v].hold - int'(DEB) - 4);
      end else begin
        tick(vecs[v].hold - int'(DEB) - 3);
      end
      key_n = '1;
      exp_q.push_back(vecs[v].evt0 | 8'h40);
      if (vecs[v].n_evt == 2) exp_q.push_back(vecs[v].evt1 | 8'h40);
      tick(DEB + 2);
      check("lvl_pre_fall", 32'(btn_level), 32'(vecs[v].lvl));
      tick(1);
      check("lvl_fall", 32'(btn_level), 32'd0);
      wait_drain("press_drain", 10);
    end

    // Backpressure: fill FIFO, hold one pending, lose one to overflow
    evt_ready = 1'b0;
    repeat (2) begin
      key_n[0] = 1'b0; tick(DEB + 4);
      key_n[0] = 1'b1; tick(DEB + 4);
    end
    key_n[0] = 1'b0; tick(DEB + 4);
    check("bp_valid",    32'(evt_valid),    32'd1);
    check("bp_head_held", 32'(evt_data),    32'h00);
    check("bp_no_ovf",   32'(evt_overflow), 32'd0);
    key_n[0] = 1'b1; tick(DEB + 4);
    check("bp_ovf_set",  32'(evt_overflow), 32'd1);
    exp_q.push_back(8'h00); exp_q.push_back(8'h40);
    exp_q.push_back(8'h00); exp_q.push_back(8'h40);
    exp_q.push_back(8'h00);
    evt_ready = 1'b1;
    wait_drain("bp_drain", 20);
    tick(3);
    check("bp_empty",      32'(evt_valid),    32'd0);
    check("bp_ovf_sticky", 32'(evt_overflow), 32'd1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_clr", 32'(evt_overflow), 32'd0);

    // Reset while pressed with two queued events
    evt_ready = 1'b0;
    key_n = 2'b00;
    tick(DEB + 4);
    check("rst_mid_lvl",   32'(btn_level), 32'd3);
    check("rst_mid_valid", 32'(evt_valid), 32'd1);
    reset_reset_n = 1'b0;
    key_n = '1;
    tick(1);
    reset_reset_n = 1'b1;
    check("rst_mid_lvl0",   32'(btn_level), 32'd0);
    check("rst_mid_valid0", 32'(evt_valid), 32'd0);
    check("rst_mid_data0",  32'(evt_data),  32'd0);
    evt_ready = 1'b1;
    tick(40);
    check("rst_no_release", 32'(evt_valid), 32'd0);

    // Long hold on channel 1
    key_n[1] = 1'b0;
    exp_q.push_back(8'h01);
    tick(DEB + 3);
    check("lp_rise", 32'(btn_level), 32'd2);
    tick(LONG - 1);
    check("lp_before", 32'(evt_valid), 32'd0);
`ifdef LONG_PRESS_EN
    exp_q.push_back(8'h81);
    tick(1);
    check("lp_evt", 32'({evt_valid, evt_data}), 32'({1'b1, 8'h81}));
`else
    tick(1);
    check("lp_none", 32'(evt_valid), 32'd0);
`endif
    tick(60 - int'(DEB) - 3 - int'(LONG));
    key_n[1] = 1'b1;
    exp_q.push_back(8'h41);
    tick(DEB + 3);
    check("lp_fall", 32'(btn_level), 32'd0);
    wait_drain("lp_drain", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
